// File: rtl/fetch_pipe_stage.sv
// Fetch-to-decode pipeline register with a one-entry skid buffer and jump flush.
// Output register feeds the decoder; the skid absorbs one word while the decoder stalls.
// After a taken jump, wrong-path words are discarded and a bubble opcode is presented.
module fetch_pipe_stage #(
   parameter logic [7:0]  BUBBLE_OP    = 8'hC8,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic             clk,
   input  logic             sync_reset,
   input  logic [7:0]       pm_data,
   input  logic [7:0]       pm_address,
   input  logic             fetch_valid,
   output logic             fetch_ready,
   input  logic             jump_taken,
   input  logic             stall,
   output logic [7:0]       ir_next,
   output logic [7:0]       ir_pc,
   output logic             ir_valid,
   output logic [7:0]       flush_count,
   output logic [CNT_W-1:0] instr_count,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      StRun   = 2'd0,
      StHold  = 2'd1,
      StFlush = 2'd2
   } state_e;

   state_e     state_q;
   logic [7:0] skid_data_q;
   logic [7:0] skid_addr_q;
   logic       skid_full_q;
   logic [1:0] flush_left_q;

   logic consume;
   logic discard_on_jump;

   // Decoder takes the presented word; never on a jump edge.
   assign consume         = ir_valid && !stall && !jump_taken;
   // A word arriving on a jump edge counts as discarded only if the stage could accept it.
   assign discard_on_jump = jump_taken && fetch_valid && !skid_full_q;

   // Ready whenever the skid has room; state is exported for debug.
   always_comb begin
      fetch_ready = !skid_full_q;
      state_dbg   = state_q;
   end

   // Pipeline FSM, output register, skid buffer and counters.
   always_ff @(posedge clk) begin
      if (sync_reset) begin
         state_q      <= StRun;
         skid_data_q  <= 8'h00;
         skid_addr_q  <= 8'h00;
         skid_full_q  <= 1'b0;
         flush_left_q <= 2'd0;
         ir_next      <= BUBBLE_OP;
         ir_pc        <= 8'h00;
         ir_valid     <= 1'b0;
         flush_count  <= 8'h00;
         instr_count  <= '0;
      end else begin
         if (consume) begin
            instr_count <= instr_count + CNT_W'(1);
         end

         if (jump_taken) begin
            // ir_pc is deliberately left alone so it still tags the last real word.
            ir_next      <= BUBBLE_OP;
            ir_valid     <= 1'b0;
            skid_full_q  <= 1'b0;
            flush_left_q <= 2'(FLUSH_CYCLES);
            state_q      <= StFlush;
            if (discard_on_jump && flush_count != 8'hFF) begin
               flush_count <= flush_count + 8'd1;
            end
         end else begin
            unique case (state_q)
               StRun: begin
                  if (!stall) begin
                     if (fetch_valid) begin
                        ir_next  <= pm_data;
                        ir_pc    <= pm_address;
                        ir_valid <= 1'b1;
                     end else begin
                        ir_next  <= BUBBLE_OP;
                        ir_valid <= 1'b0;
                     end
                  end else if (fetch_valid) begin
                     skid_data_q <= pm_data;
                     skid_addr_q <= pm_address;
                     skid_full_q <= 1'b1;
                     state_q     <= StHold;
                  end
               end
               StHold: begin
                  // Upstream must be idle here; fetch_valid is ignored.
                  if (!stall) begin
                     ir_next     <= skid_data_q;
                     ir_pc       <= skid_addr_q;
                     ir_valid    <= 1'b1;
                     skid_full_q <= 1'b0;
                     state_q     <= StRun;
                  end
               end
               StFlush: begin
                  // Only real wrong-path words advance the flush; stall is irrelevant.
                  if (fetch_valid) begin
                     if (flush_count != 8'hFF) begin
                        flush_count <= flush_count + 8'd1;
                     end
                     flush_left_q <= flush_left_q - 2'd1;
                     if (flush_left_q <= 2'd1) begin
                        state_q <= StRun;
                     end
                  end
               end
               default: begin
                  state_q <= StRun;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_pipe_stage.sv
// Directed bench for fetch_pipe_stage with a scoreboard of expected decoder words.
module tb_fetch_pipe_stage;

   logic        clk;
   logic        sync_reset;
   logic [7:0]  pm_data;
   logic [7:0]  pm_address;
   logic        fetch_valid;
   logic        fetch_ready;
   logic        jump_taken;
   logic        stall;
   logic [7:0]  ir_next;
   logic [7:0]  ir_pc;
   logic        ir_valid;
   logic [7:0]  flush_count;
   logic [15:0] instr_count;
   logic [1:0]  state_dbg;

   int          checks;
   int          failures;
   logic [15:0] model_cnt;
   logic [15:0] sb[$];

   fetch_pipe_stage #(
      .BUBBLE_OP   (8'hC8),
      .FLUSH_CYCLES(1),
      .CNT_W       (16)
   ) dut (
      .clk        (clk),
      .sync_reset (sync_reset),
      .pm_data    (pm_data),
      .pm_address (pm_address),
      .fetch_valid(fetch_valid),
      .fetch_ready(fetch_ready),
      .jump_taken (jump_taken),
      .stall      (stall),
      .ir_next    (ir_next),
      .ir_pc      (ir_pc),
      .ir_valid   (ir_valid),
      .flush_count(flush_count),
      .instr_count(instr_count),
      .state_dbg  (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive one cycle; pop the scoreboard when the decoder consumes, push when a word is accepted.
   task automatic step(input logic fv, input logic [7:0] d, input logic [7:0] a,
                       input logic st, input logic jt, input logic push);
      logic [15:0] exp;
      fetch_valid = fv;
      pm_data     = d;
      pm_address  = a;
      stall       = st;
      jump_taken  = jt;
      if (ir_valid && !st && !jt) begin
         if (sb.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            exp = sb.pop_front();
            chk("consume_data", {24'd0, ir_next}, {24'd0, exp[15:8]});
            chk("consume_pc", {24'd0, ir_pc}, {24'd0, exp[7:0]});
         end
         model_cnt++;
      end
      if (push) sb.push_back({d, a});
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_state();
      chk("rst_ir_next", {24'd0, ir_next}, 32'hC8);
      chk("rst_ir_pc", {24'd0, ir_pc}, 32'h0);
      chk("rst_ir_valid", {31'd0, ir_valid}, 32'd0);
      chk("rst_ready", {31'd0, fetch_ready}, 32'd1);
      chk("rst_state", {30'd0, state_dbg}, 32'd0);
      chk("rst_flush", {24'd0, flush_count}, 32'd0);
      chk("rst_icount", {16'd0, instr_count}, 32'd0);
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      model_cnt   = 16'd0;
      sync_reset  = 1'b1;
      fetch_valid = 1'b0;
      pm_data     = 8'h00;
      pm_address  = 8'h00;
      stall       = 1'b0;
      jump_taken  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk_reset_state();
      sync_reset = 1'b0;

      // Plain streaming, one-cycle latency.
      step(1'b1, 8'h11, 8'd0, 1'b0, 1'b0, 1'b1);
      chk("s1_data", {24'd0, ir_next}, 32'h11);
      chk("s1_valid", {31'd0, ir_valid}, 32'd1);
      step(1'b1, 8'h22, 8'd1, 1'b0, 1'b0, 1'b1);
      chk("s2_pc", {24'd0, ir_pc}, 32'd1);
      step(1'b1, 8'h33, 8'd2, 1'b0, 1'b0, 1'b1);
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("s_icount", {16'd0, instr_count}, 32'd3);
      chk("s_bubble", {24'd0, ir_next}, 32'hC8);
      chk("s_pc_held", {24'd0, ir_pc}, 32'd2);
      chk("s_valid0", {31'd0, ir_valid}, 32'd0);

      // Stall absorbed by the skid.
      step(1'b1, 8'h40, 8'd5, 1'b0, 1'b0, 1'b1);
      step(1'b1, 8'h41, 8'd6, 1'b1, 1'b0, 1'b1);
      chk("h_state", {30'd0, state_dbg}, 32'd1);
      chk("h_ready", {31'd0, fetch_ready}, 32'd0);
      chk("h_data", {24'd0, ir_next}, 32'h40);
      step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("h2_data", {24'd0, ir_next}, 32'h40);
      chk("h2_state", {30'd0, state_dbg}, 32'd1);
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("h_rel_data", {24'd0, ir_next}, 32'h41);
      chk("h_rel_pc", {24'd0, ir_pc}, 32'd6);
      chk("h_rel_ready", {31'd0, fetch_ready}, 32'd1);
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("h_icount", {16'd0, instr_count}, 32'd5);

      // Jump flush: jump-edge word plus one more are discarded.
      step(1'b1, 8'h50, 8'd8, 1'b0, 1'b1, 1'b0);
      chk("j_state", {30'd0, state_dbg}, 32'd2);
      chk("j_valid", {31'd0, ir_valid}, 32'd0);
      step(1'b1, 8'h51, 8'd9, 1'b0, 1'b0, 1'b0);
      chk("j_flush", {24'd0, flush_count}, 32'd2);
      chk("j_bubble", {24'd0, ir_next}, 32'hC8);
      chk("j_back_run", {30'd0, state_dbg}, 32'd0);
      step(1'b1, 8'h60, 8'd3, 1'b0, 1'b0, 1'b1);
      chk("j_next_data", {24'd0, ir_next}, 32'h60);
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("j_icount", {16'd0, instr_count}, 32'd6);

      // Jump with stall while in HOLD; neither held word is ever consumed.
      step(1'b1, 8'h70, 8'd4, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h71, 8'd5, 1'b1, 1'b0, 1'b0);
      chk("jh_hold", {30'd0, state_dbg}, 32'd1);
      step(1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
      chk("jh_state", {30'd0, state_dbg}, 32'd2);
      chk("jh_valid", {31'd0, ir_valid}, 32'd0);
      chk("jh_ready", {31'd0, fetch_ready}, 32'd1);
      chk("jh_icount", {16'd0, instr_count}, 32'd6);
      step(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("jh_idle_flush", {30'd0, state_dbg}, 32'd2);
      step(1'b1, 8'h72, 8'd6, 1'b1, 1'b0, 1'b0);
      chk("jh_run", {30'd0, state_dbg}, 32'd0);
      chk("jh_flush", {24'd0, flush_count}, 32'd3);

      // Saturation of the discard counter.
      for (int i = 0; i < 300; i++) begin
         step(1'b1, 8'(i), 8'(i), 1'b0, 1'b1, 1'b0);
      end
      step(1'b1, 8'hAA, 8'hAA, 1'b0, 1'b0, 1'b0);
      chk("sat_flush", {24'd0, flush_count}, 32'hFF);
      chk("sat_state", {30'd0, state_dbg}, 32'd0);

      // Run the issue counter up to its top value, then wrap it.
      for (int i = 0; i < 70000; i++) begin
         if (model_cnt == 16'hFFFF) break;
         step(1'b1, 8'(i), 8'(i + 1), 1'b0, 1'b0, 1'b1);
      end
      chk("wrap_top", {16'd0, instr_count}, 32'hFFFF);
      step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
      chk("wrap_zero", {16'd0, instr_count}, {16'd0, model_cnt});
      chk("wrap_sb_empty", sb.size(), 32'd0);

      // Reset from HOLD with a full skid.
      step(1'b1, 8'h80, 8'd1, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h81, 8'd2, 1'b1, 1'b0, 1'b0);
      chk("rh_hold", {30'd0, state_dbg}, 32'd1);
      sync_reset  = 1'b1;
      fetch_valid = 1'b1;
      stall       = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_state();
      sync_reset  = 1'b0;
      fetch_valid = 1'b0;
      stall       = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_pipe_stage.md
Name: fetch_pipe_stage

Overview:
- Pipeline register stage between program_memory and instruction_decoder in the pipelined CME341 microprocessor.
- Captures each fetched word with its program address and presents it to the decoder with a valid flag.
- Absorbs decoder stalls with a one-entry skid buffer, so no fetched word is lost.
- Discards wrong-path words after a taken jump and injects a bubble opcode in their place.

Parameters:
- BUBBLE_OP, 8'hC8, opcode driven on ir_next whenever ir_valid is 0 (decoder treats it as a NOP).
- FLUSH_CYCLES, 1, number of incoming words discarded after a taken jump. Range 1-3.
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- sync_reset  in  1  synchronous, active-high reset.
- pm_data  in  8  word read from program memory this cycle.
- pm_address  in  8  address that produced pm_data.
- fetch_valid  in  1  pm_data/pm_address are meaningful.
- fetch_ready  out  1  stage can accept a word this cycle. Combinational: 1 when the skid is empty.
- jump_taken  in  1  decoder/sequencer resolved a taken jump this cycle.
- stall  in  1  decoder cannot consume ir_next this cycle.
- ir_next  out  8  instruction presented to the decoder.
- ir_pc  out  8  address of ir_next.
- ir_valid  out  1  ir_next is a real instruction.
- flush_count  out  8  saturating count of discarded words.
- instr_count  out  CNT_W  wrapping count of instructions consumed by the decoder.
- state_dbg  out  2  current FSM state (RUN=0, HOLD=1, FLUSH=2).

Behaviour:
- Reset (sync_reset=1 at a rising edge):
  - state=RUN, skid empty, ir_next=BUBBLE_OP, ir_pc=0, ir_valid=0.
  - flush_count=0, instr_count=0, fetch_ready=1.
  - Reset overrides every other input, including mid-flush or mid-hold.
- Consume event: ir_valid=1 and stall=0 at a clock edge. Each consume increments instr_count modulo 2^CNT_W.
- RUN state (skid empty):
  - stall=0 and fetch_valid=1: output register <= {pm_data, pm_address}, ir_valid<=1. Latency is one cycle from fetch to decoder.
  - stall=0 and fetch_valid=0: ir_next<=BUBBLE_OP, ir_valid<=0.
  - stall=1 and fetch_valid=1: output register holds; skid <= the incoming word; next state HOLD.
  - stall=1 and fetch_valid=0: everything holds.
- HOLD state (skid full, fetch_ready=0):
  - Upstream must not present a new word; any fetch_valid in this state is ignored and not counted.
  - stall=1: hold.
  - stall=0: output <= skid, skid cleared, next state RUN.
- jump_taken=1 in any state (priority over stall and fetch):
  - Output register is set to bubble (ir_valid<=0, ir_next<=BUBBLE_OP); skid cleared.
  - The word arriving on the same edge is discarded; next state FLUSH with an internal counter loaded to FLUSH_CYCLES.
  - The current output is not consumed on the jump edge; instr_count does not increment.
- FLUSH state:
  - Each cycle with fetch_valid=1 discards the word and decrements the counter. Each discard increments flush_count, saturating at 8'hFF.
  - The word discarded on the jump edge also counts.
  - Output stays bubble. When the counter reaches 0, the next state is RUN.
  - fetch_ready=1 throughout; stall is ignored.
  - A new jump_taken in FLUSH reloads the counter to FLUSH_CYCLES.
- fetch_valid=0 during FLUSH does not decrement the counter; only real wrong-path words are consumed.
- ir_pc always accompanies its ir_next; ir_pc is held, not zeroed, when a bubble is inserted.
- No combinational path from pm_data to ir_next.

Test Plan:
- Reset, then stream words 0x11,0x22,0x33 at addresses 0,1,2 with stall=0 -> each appears on ir_next one cycle later with ir_valid=1 and matching ir_pc; instr_count=3.
- Stream 0x40@5, 0x41@6; assert stall for 2 cycles as 0x41 arrives -> ir_next holds 0x40, state_dbg=1, fetch_ready=0; on release 0x41@6 appears; no word is lost or duplicated.
- Assert jump_taken while 0x50@8 arrives, then 0x51@9 -> both discarded, ir_valid=0, ir_next=8'hC8, flush_count=2; the next word 0x60@3 issues normally.
- Assert jump_taken and stall together in HOLD -> skid and output cleared, state FLUSH, stall ignored, instr_count unchanged.
- Drive 300 jump flushes -> flush_count saturates at 8'hFF. Separately preload instr_count at 16'hFFFF and consume one instruction -> wraps to 0.
- Assert sync_reset during HOLD with a full skid -> next cycle all outputs at reset values, state RUN, fetch_ready=1.
